// File: rtl/row_router_addr_gen.sv
// Raster-order coordinate walker that feeds ROUTER_COUNT row routers one group per handshake.
// A partial final group is masked by per-lane valid bits.
module row_router_addr_gen #(
  parameter int ROUTER_COUNT = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter bit WRAP         = 1'b0
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic                                   i_reg_clear,
  input  logic                                   i_start,
  input  logic [ADDR_WIDTH-1:0]                  i_o_x,
  input  logic [ADDR_WIDTH-1:0]                  i_o_y,
  input  logic [ADDR_WIDTH-1:0]                  i_o_width,
  input  logic [ADDR_WIDTH-1:0]                  i_o_height,
  input  logic                                   i_ready,
  output logic [ROUTER_COUNT-1:0][ADDR_WIDTH-1:0] o_x,
  output logic [ROUTER_COUNT-1:0][ADDR_WIDTH-1:0] o_y,
  output logic [ROUTER_COUNT-1:0]                o_lane_valid,
  output logic                                   o_valid,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int IW = $clog2(ROUTER_COUNT + 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] w, h;
  logic [ADDR_WIDTH-1:0] cur_x, cur_y;
  logic [ADDR_WIDTH-1:0] nxt_x, nxt_y;
  logic [ADDR_WIDTH:0]   x_inc, y_inc;
  logic                  nxt_end;
  logic                  ended;
  logic [IW-1:0]         idx;

  // Successor of the most recently generated coordinate (cur); one extra bit keeps the
  // increment compare safe at the top of the ADDR_WIDTH range.
  assign x_inc = {1'b0, cur_x} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign y_inc = {1'b0, cur_y} + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    nxt_end = 1'b0;
    if (y_inc < {1'b0, w}) begin
      nxt_y = y_inc[ADDR_WIDTH-1:0];
    end else begin
      nxt_y = '0;
      if (x_inc < {1'b0, h}) begin
        nxt_x = x_inc[ADDR_WIDTH-1:0];
      end else if (WRAP) begin
        nxt_x = '0;
      end else begin
        nxt_x   = '0;
        nxt_end = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      state        <= IDLE;
      w            <= '0;
      h            <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      ended        <= 1'b0;
      idx          <= '0;
      o_x          <= '0;
      o_y          <= '0;
      o_lane_valid <= '0;
      o_valid      <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            w      <= i_o_width;
            h      <= i_o_height;
            o_busy <= 1'b1;
            if (i_o_width == '0 || i_o_height == '0 ||
                i_o_x >= i_o_height || i_o_y >= i_o_width) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              o_x[0]       <= i_o_x;
              o_y[0]       <= i_o_y;
              o_lane_valid <= ROUTER_COUNT'(1);
              cur_x        <= i_o_x;
              cur_y        <= i_o_y;
              ended        <= 1'b0;
              idx          <= IW'(1);
              state        <= FILL;
            end
          end
        end

        FILL: begin
          if (idx == IW'(ROUTER_COUNT)) begin
            o_valid <= 1'b1;
            state   <= HOLD;
          end else begin
            for (int k = 1; k < ROUTER_COUNT; k++) begin
              if (idx == IW'(k)) begin
                if (ended || nxt_end) begin
                  o_x[k]          <= '0;
                  o_y[k]          <= '0;
                  o_lane_valid[k] <= 1'b0;
                end else begin
                  o_x[k]          <= nxt_x;
                  o_y[k]          <= nxt_y;
                  o_lane_valid[k] <= 1'b1;
                end
              end
            end
            // once the map end is seen, cur is frozen and later lanes stay empty
            if (!ended) begin
              cur_x <= nxt_x;
              cur_y <= nxt_y;
              ended <= nxt_end;
            end
            idx <= idx + IW'(1);
          end
        end

        HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            // a full group that ends exactly on the last point must not start an empty group
            if (ended || nxt_end) begin
              o_x          <= '0;
              o_y          <= '0;
              o_lane_valid <= '0;
              o_done       <= 1'b1;
              state        <= DONE;
            end else begin
              o_x[0]       <= nxt_x;
              o_y[0]       <= nxt_y;
              o_lane_valid <= ROUTER_COUNT'(1);
              cur_x        <= nxt_x;
              cur_y        <= nxt_y;
              idx          <= IW'(1);
              state        <= FILL;
            end
          end
        end

        DONE: begin
          o_x          <= '0;
          o_y          <= '0;
          o_lane_valid <= '0;
          o_done       <= 1'b0;
          o_busy       <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_router_addr_gen.sv
// Self-checking bench for row_router_addr_gen: a linear-index model of the raster walk
// predicts every group; one DUT stops at map end, a second one wraps.
module tb_row_router_addr_gen;
  localparam int N  = 4;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clr, start, ready, start2, ready2;
  logic [AW-1:0] sx_in, sy_in, wd, ht;
  logic [N-1:0][AW-1:0] x1, y1, x2, y2;
  logic [N-1:0]  lv1, lv2;
  logic          v1, b1, d1, v2, b2, d2;
  int            total = 0;
  int            bad   = 0;

  row_router_addr_gen #(.ROUTER_COUNT(N), .ADDR_WIDTH(AW), .WRAP(1'b0)) dut (
    .i_clk(clk), .i_nrst(rst_n), .i_reg_clear(clr), .i_start(start),
    .i_o_x(sx_in), .i_o_y(sy_in), .i_o_width(wd), .i_o_height(ht), .i_ready(ready),
    .o_x(x1), .o_y(y1), .o_lane_valid(lv1), .o_valid(v1), .o_busy(b1), .o_done(d1));

  row_router_addr_gen #(.ROUTER_COUNT(N), .ADDR_WIDTH(AW), .WRAP(1'b1)) dut_wrap (
    .i_clk(clk), .i_nrst(rst_n), .i_reg_clear(clr), .i_start(start2),
    .i_o_x(sx_in), .i_o_y(sy_in), .i_o_width(wd), .i_o_height(ht), .i_ready(ready2),
    .o_x(x2), .o_y(y2), .o_lane_valid(lv2), .o_valid(v2), .o_busy(b2), .o_done(d2));

  // Point p of the map (row-major linear index) lives at row p/W, column p%W.
  task automatic model_group(input int w, input int h, input int lin0, input int g, input bit wrap,
                             output logic [N-1:0][AW-1:0] ex, output logic [N-1:0][AW-1:0] ey,
                             output logic [N-1:0] ev);
    int tot;
    int p;
    tot = w * h;
    for (int k = 0; k < N; k++) begin
      p = lin0 + g * N + k;
      if (wrap) p = p % tot;
      if (p < tot) begin
        ex[k] = AW'(p / w); ey[k] = AW'(p % w); ev[k] = 1'b1;
      end else begin
        ex[k] = '0; ey[k] = '0; ev[k] = 1'b0;
      end
    end
  endtask

  task automatic test_traversal(input string nm, input int w, input int h, input int sx,
                                input int sy, input int stall_first, input int max_stall);
    int lin0, ng, n, s;
    logic [N-1:0][AW-1:0] ex, ey;
    logic [N-1:0] ev;
    lin0 = sx * w + sy;
    ng   = (w * h - lin0 + N - 1) / N;
    wd = AW'(w); ht = AW'(h); sx_in = AW'(sx); sy_in = AW'(sy);
    start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < ng; g++) begin
      n = 0;
      while (!v1 && n < 50) begin @(negedge clk); n++; end
      total++;
      if (n !== N) begin
        bad++; $display("FAIL %s latency g=%0d: got %0d want %0d", nm, g, n, N);
      end
      model_group(w, h, lin0, g, 1'b0, ex, ey, ev);
      total++;
      if ({x1, y1, lv1} !== {ex, ey, ev}) begin
        bad++; $display("FAIL %s group g=%0d: got x=%h y=%h m=%b want x=%h y=%h m=%b",
                        nm, g, x1, y1, lv1, ex, ey, ev);
      end
      total++;
      if (b1 !== 1'b1 || d1 !== 1'b0) begin
        bad++; $display("FAIL %s busy/done g=%0d: got %b%b want 10", nm, g, b1, d1);
      end
      s = (g == 0) ? stall_first : ((max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0);
      repeat (s) begin
        @(negedge clk);
        total++;
        if (v1 !== 1'b1 || {x1, y1, lv1} !== {ex, ey, ev}) begin
          bad++; $display("FAIL %s stall g=%0d: got v=%b x=%h y=%h m=%b want v=1 x=%h y=%h m=%b",
                          nm, g, v1, x1, y1, lv1, ex, ey, ev);
        end
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      total++;
      if (v1 !== 1'b0) begin
        bad++; $display("FAIL %s valid_drop g=%0d: got %b want 0", nm, g, v1);
      end
    end
    total++;
    if (d1 !== 1'b1 || lv1 !== '0 || x1 !== '0 || y1 !== '0) begin
      bad++; $display("FAIL %s done_pulse: got d=%b m=%b x=%h want d=1 m=0 x=0", nm, d1, lv1, x1);
    end
    @(negedge clk);
    total++;
    if (d1 !== 1'b0 || b1 !== 1'b0 || v1 !== 1'b0) begin
      bad++; $display("FAIL %s idle_after: got d=%b b=%b v=%b want 000", nm, d1, b1, v1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; ready = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    wd = '0; ht = '0; sx_in = '0; sy_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({x1, y1, lv1, v1, b1, d1, x2, y2, lv2, v2, b2, d2} !== '0) begin
      bad++; $display("FAIL reset: got x=%h y=%h m=%b v=%b b=%b d=%b want all 0",
                      x1, y1, lv1, v1, b1, d1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_invalid();
    int cw[4] = '{0, 3, 3, 3};
    int ch[4] = '{3, 3, 3, 0};
    int cx[4] = '{0, 3, 0, 0};
    int cy[4] = '{0, 0, 3, 0};
    for (int i = 0; i < 4; i++) begin
      wd = AW'(cw[i]); ht = AW'(ch[i]); sx_in = AW'(cx[i]); sy_in = AW'(cy[i]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (d1 !== 1'b1 || v1 !== 1'b0 || b1 !== 1'b1) begin
        bad++; $display("FAIL invalid%0d pulse: got d=%b v=%b b=%b want d=1 v=0 b=1", i, d1, v1, b1);
      end
      @(negedge clk);
      total++;
      if (d1 !== 1'b0 || v1 !== 1'b0 || b1 !== 1'b0) begin
        bad++; $display("FAIL invalid%0d idle: got d=%b v=%b b=%b want 000", i, d1, v1, b1);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [N-1:0][AW-1:0] ex, ey;
    logic [N-1:0] ev;
    wd = 2; ht = 2; sx_in = 1; sy_in = 1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!v2 && n < 50) begin
        @(negedge clk); n++;
        total++;
        if (d2 !== 1'b0 || b2 !== 1'b1) begin
          bad++; $display("FAIL wrap busy/done g=%0d: got b=%b d=%b want b=1 d=0", g, b2, d2);
        end
      end
      model_group(2, 2, 3, g, 1'b1, ex, ey, ev);
      total++;
      if (n !== N || {x2, y2, lv2} !== {ex, ey, ev}) begin
        bad++; $display("FAIL wrap group g=%0d: got lat=%0d x=%h y=%h m=%b want lat=%0d x=%h y=%h m=%b",
                        g, n, x2, y2, lv2, N, ex, ey, ev);
      end
      ready2 = 1'b1;
      @(negedge clk);
      ready2 = 1'b0;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (b2 !== 1'b0 || v2 !== 1'b0 || lv2 !== '0) begin
      bad++; $display("FAIL wrap clear: got b=%b v=%b m=%b want 0", b2, v2, lv2);
    end
  endtask

  task automatic test_clear_reset();
    int n;
    wd = 3; ht = 3; sx_in = 0; sy_in = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if ({x1, y1, lv1, v1, b1, d1} !== '0) begin
      bad++; $display("FAIL clear_fill: got x=%h y=%h m=%b v=%b b=%b d=%b want all 0",
                      x1, y1, lv1, v1, b1, d1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!v1 && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({x1, y1, lv1, v1, b1, d1} !== '0) begin
      bad++; $display("FAIL reset_hold: got x=%h y=%h m=%b v=%b b=%b d=%b want all 0",
                      x1, y1, lv1, v1, b1, d1);
    end
    test_traversal("after_reset", 3, 3, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int w, h;
    for (int i = 0; i < 20; i++) begin
      w = int'($urandom_range(6, 1));
      h = int'($urandom_range(6, 1));
      test_traversal("random", w, h, int'($urandom_range(h - 1, 0)),
                     int'($urandom_range(w - 1, 0)), int'($urandom_range(2, 0)), 2);
    end
  endtask

  initial begin
    test_reset();
    test_traversal("basic", 3, 3, 0, 0, 0, 0);
    test_traversal("stall", 3, 3, 0, 0, 5, 0);
    test_traversal("single", 3, 2, 1, 2, 0, 0);
    test_traversal("exact_fit", 4, 2, 0, 0, 1, 1);
    test_invalid();
    test_wrap();
    test_clear_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
